// File: rtl/mix_pkg.sv
// Shared constants, types and helpers for the mix_round encoder and the
// mix_unround decoder.
package mix_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int BLK_W  = LANES * LANE_W;

  // Shift distances of the B and C steps
  localparam int SH_B = 16;
  localparam int SH_C = 17;

  // Neighbour lane offsets of the A, B and C steps (taken mod LANES)
  localparam int OFF_A = -1;
  localparam int OFF_B = 3;
  localparam int OFF_C = 2;

  localparam logic [LANE_W-1:0] RC_BASE = 32'h9E3779B9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC,
    ST_PB,
    ST_PA,
    ST_DONE
  } state_e;

  // Which inverse step the combinational phase block applies
  typedef enum logic [1:0] {
    PH_C,
    PH_B,
    PH_A
  } phase_e;

  // Round constant of round r: (r+1) * RC_BASE, wrapped to 32 bits
  function automatic logic [LANE_W-1:0] rc_of(input logic [4:0] r);
    logic [LANE_W-1:0] n;
    n = {27'd0, r} + 32'd1;
    return n * RC_BASE;
  endfunction

  // Lane index i+off wrapped into 0..LANES-1
  function automatic logic [2:0] lane_idx(input int i, input int off);
    int t;
    t = (i + off + LANES) % LANES;
    return t[2:0];
  endfunction

endpackage

// File: rtl/mix_unphase.sv
// One inverse phase of the mixing round. Lanes are updated from 7 down to 0,
// each step seeing the values already rewritten by the steps before it, so
// the chain exactly undoes the encoder's 0-to-7 in-place order.
module mix_unphase
  import mix_pkg::*;
(
  input  logic [BLK_W-1:0]  lanes_i,
  input  phase_e            phase_i,
  input  logic [LANE_W-1:0] rc_i,
  output logic [BLK_W-1:0]  lanes_o
);

  logic [LANE_W-1:0] l [LANES];
  logic [2:0]        idx;
  logic [2:0]        src;

  // Unpack, run the selected 8-step chain in place, repack
  always_comb begin
    idx = '0;
    src = '0;
    for (int k = 0; k < LANES; k++) begin
      l[3'(k)] = lanes_i[k*LANE_W +: LANE_W];
    end
    case (phase_i)
      PH_C: begin
        // The round constant was the encoder's last touch, so it comes off first
        l[0] = l[0] ^ rc_i;
        for (int k = LANES - 1; k >= 0; k--) begin
          idx    = 3'(k);
          src    = lane_idx(k, OFF_C);
          l[idx] = l[idx] + (l[src] >> SH_C);
        end
      end
      PH_B: begin
        for (int k = LANES - 1; k >= 0; k--) begin
          idx    = 3'(k);
          src    = lane_idx(k, OFF_B);
          l[idx] = l[idx] ^ (l[src] << SH_B);
        end
      end
      PH_A: begin
        for (int k = LANES - 1; k >= 0; k--) begin
          idx    = 3'(k);
          src    = lane_idx(k, OFF_A);
          l[idx] = l[idx] - l[src];
        end
      end
      default: ;
    endcase
    lanes_o = '0;
    for (int k = 0; k < LANES; k++) begin
      lanes_o[k*LANE_W +: LANE_W] = l[3'(k)];
    end
  end

endmodule

// File: rtl/mix_unround.sv
// Iterative decoder for the 8-lane ARX mix: one inverse phase per cycle,
// three phases per round, rounds walked from ROUNDS-1 down to 0.
module mix_unround
  import mix_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);

  localparam logic [4:0] RC_LAST = 5'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [4:0]        rc_q, rc_d;
  logic [BLK_W-1:0]  lanes_q, lanes_d;
  phase_e            phase;
  logic [BLK_W-1:0]  phase_out;

  mix_unphase u_phase (
    .lanes_i (lanes_q),
    .phase_i (phase),
    .rc_i    (rc_of(rc_q)),
    .lanes_o (phase_out)
  );

  // State, round counter and lane register; reset discards any block in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rc_q    <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      lanes_q <= lanes_d;
    end
  end

  // Next-state logic: capture in IDLE, PC -> PB -> PA per round, hold in DONE
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    lanes_d = lanes_q;
    phase   = PH_C;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          lanes_d = in_data;
          rc_d    = RC_LAST;
          state_d = ST_PC;
        end
      end
      ST_PC: begin
        phase   = PH_C;
        lanes_d = phase_out;
        state_d = ST_PB;
      end
      ST_PB: begin
        phase   = PH_B;
        lanes_d = phase_out;
        state_d = ST_PA;
      end
      ST_PA: begin
        phase   = PH_A;
        lanes_d = phase_out;
        if (rc_q == 5'd0) begin
          state_d = ST_DONE;
        end else begin
          rc_d    = rc_q - 5'd1;
          state_d = ST_PC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is gated by reset so it reads low while reset is held
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = lanes_q;

endmodule
